// File: rtl/approx_sweep_pkg.sv
// Shared types and width helpers for the approximate-multiplier error sweep.
package approx_sweep_pkg;

   // Sweep controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sweep_state_e;

   // Error counter width: one bit wider than the product so 2^(2*WIDTH) errors fit
   function automatic int cnt_w(input int width);
      return 2 * width + 1;
   endfunction

   // Signed difference width: product width plus a sign bit
   function automatic int diff_w(input int width);
      return 2 * width + 1;
   endfunction

endpackage

// File: rtl/approx_err_acc.sv
// Tail compare/accumulate stage: compares one multiplier result against the
// exact product and folds the error into the running statistics.
// Optional signed bias sum built only with APPROX_ERR_SWEEP_ERR_BIAS_EN.
module approx_err_acc
   import approx_sweep_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SUM_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr_i,
   input  logic                      valid_i,
   input  logic [WIDTH-1:0]          a_i,
   input  logic [WIDTH-1:0]          b_i,
   input  logic [2*WIDTH-1:0]        c_i,
   output logic [cnt_w(WIDTH)-1:0]   err_count_o,
   output logic [SUM_W-1:0]          sum_abs_err_o,
   output logic [2*WIDTH-1:0]        max_abs_err_o,
   output logic [2*WIDTH+SUM_W-1:0]  sum_err_o
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = cnt_w(WIDTH);

   logic [PW-1:0] exact;
   logic [PW-1:0] abs_diff;
   logic          is_err;

   logic [CW-1:0]    cnt_q;
   logic [SUM_W-1:0] sum_q;
   logic [PW-1:0]    max_q;

   // Exact product and unsigned error magnitude, no wide signed arithmetic needed
   always_comb begin
      exact    = PW'(a_i) * PW'(b_i);
      is_err   = (c_i != exact);
      abs_diff = (c_i < exact) ? (exact - c_i) : (c_i - exact);
   end

   // Error count, magnitude sum and peak magnitude; cleared at sweep start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         sum_q <= '0;
         max_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
         sum_q <= '0;
         max_q <= '0;
      end else if (valid_i && is_err) begin
         cnt_q <= cnt_q + 1'b1;
         sum_q <= sum_q + SUM_W'(abs_diff);
         if (abs_diff > max_q) begin
            max_q <= abs_diff;
         end
      end
   end

   assign err_count_o   = cnt_q;
   assign sum_abs_err_o = sum_q;
   assign max_abs_err_o = max_q;

`ifdef APPROX_ERR_SWEEP_ERR_BIAS_EN
   localparam int DW = diff_w(WIDTH);
   localparam int BW = 2 * WIDTH + SUM_W;

   logic signed [DW-1:0] diff;
   logic signed [BW-1:0] bias_q;

   // Signed difference result minus exact, one bit wider than the product
   always_comb begin
      diff = $signed({1'b0, c_i}) - $signed({1'b0, exact});
   end

   // Two's-complement running sum of every difference (mean-bias numerator)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bias_q <= '0;
      end else if (clr_i) begin
         bias_q <= '0;
      end else if (valid_i) begin
         bias_q <= bias_q + {{(BW-DW){diff[DW-1]}}, diff};
      end
   end

   assign sum_err_o = bias_q;
`else
   assign sum_err_o = '0;
`endif

endmodule

// File: rtl/approx_err_sweep.sv
// Exhaustive error-characterisation controller for one approximate
// WIDTHxWIDTH multiplier: walks every (a,b) pair, a outer / b inner, one per
// cycle, and accumulates error statistics on the returning results.
// Build option: APPROX_ERR_SWEEP_ERR_BIAS_EN enables the signed sum_err output.
// Handshake: start is accepted only in IDLE; abort wins over start and over
// every state; done is a single-cycle pulse with final statistics stable.
module approx_err_sweep
   import approx_sweep_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LAT   = 1,
   parameter int SUM_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   output logic                      busy,
   output logic                      done,
   output logic [WIDTH-1:0]          mul_a,
   output logic [WIDTH-1:0]          mul_b,
   input  logic [2*WIDTH-1:0]        mul_c,
   output logic [cnt_w(WIDTH)-1:0]   err_count,
   output logic [SUM_W-1:0]          sum_abs_err,
   output logic [2*WIDTH-1:0]        max_abs_err,
   output logic [2*WIDTH+SUM_W-1:0]  sum_err,
   output sweep_state_e              dbg_state_o
);

   localparam logic [WIDTH-1:0] OP_MAX     = '1;
   localparam logic [2:0]       DRAIN_LAST = 3'(LAT - 1);

   sweep_state_e     state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             busy_q;
   logic             done_q;
   logic [2:0]       drain_q;
   logic             start_acc;

   logic             pipe_v_q [LAT];
   logic [WIDTH-1:0] pipe_a_q [LAT];
   logic [WIDTH-1:0] pipe_b_q [LAT];

   assign start_acc = (state_q == ST_IDLE) && start && !abort;

   // Sweep FSM with operand counters and registered busy/done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         drain_q <= '0;
      end else if (abort) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         drain_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  a_q     <= '0;
                  b_q     <= '0;
               end
            end
            ST_RUN: begin
               // Last pair is on the bus this cycle: hold it and wait out the latency
               if (a_q == OP_MAX && b_q == OP_MAX) begin
                  state_q <= ST_DRAIN;
                  drain_q <= '0;
               end else begin
                  b_q <= b_q + 1'b1;
                  if (b_q == OP_MAX) begin
                     a_q <= a_q + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_q == DRAIN_LAST) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= drain_q + 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Operand tag pipeline aligned with the multiplier latency; abort flushes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            pipe_v_q[i] <= 1'b0;
            pipe_a_q[i] <= '0;
            pipe_b_q[i] <= '0;
         end
      end else begin
         pipe_v_q[0] <= (state_q == ST_RUN) && !abort;
         pipe_a_q[0] <= a_q;
         pipe_b_q[0] <= b_q;
         for (int i = 1; i < LAT; i++) begin
            pipe_v_q[i] <= pipe_v_q[i-1] && !abort;
            pipe_a_q[i] <= pipe_a_q[i-1];
            pipe_b_q[i] <= pipe_b_q[i-1];
         end
      end
   end

   approx_err_acc #(
      .WIDTH (WIDTH),
      .SUM_W (SUM_W)
   ) u_acc (
      .clk           (clk),
      .rst           (rst),
      .clr_i         (start_acc),
      .valid_i       (pipe_v_q[LAT-1] && !abort),
      .a_i           (pipe_a_q[LAT-1]),
      .b_i           (pipe_b_q[LAT-1]),
      .c_i           (mul_c),
      .err_count_o   (err_count),
      .sum_abs_err_o (sum_abs_err),
      .max_abs_err_o (max_abs_err),
      .sum_err_o     (sum_err)
   );

   assign busy        = busy_q;
   assign done        = done_q;
   assign mul_a       = a_q;
   assign mul_b       = b_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_approx_err_sweep.sv
// Bench for approx_err_sweep: a behavioural approximate multiplier in the loop,
// a reference model of the sweep statistics, and a scoreboard checked on done.
module tb_approx_err_sweep;
   import approx_sweep_pkg::*;

   localparam int WIDTH = 4;
   localparam int LAT   = 3;
   localparam int SUM_W = 32;
   localparam int PW    = 2 * WIDTH;
   localparam int N     = 1 << PW;
   localparam int OPS   = 1 << WIDTH;

   typedef struct {
      longint cnt;
      longint sum_abs;
      longint max_abs;
      longint bias;
      int     done_cyc;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 abort;
   logic                 busy;
   logic                 done;
   logic [WIDTH-1:0]     mul_a;
   logic [WIDTH-1:0]     mul_b;
   logic [PW-1:0]        mul_c;
   logic [PW:0]          err_count;
   logic [SUM_W-1:0]     sum_abs_err;
   logic [PW-1:0]        max_abs_err;
   logic [PW+SUM_W-1:0]  sum_err;
   sweep_state_e         dbg_state;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int mode        = 0;

   logic [PW-1:0] err_tab [N];
   logic [PW-1:0] mpipe [LAT];
   logic [PW-1:0] pair_q [$];
   exp_t          exp_q [$];

   approx_err_sweep #(
      .WIDTH (WIDTH),
      .LAT   (LAT),
      .SUM_W (SUM_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_c       (mul_c),
      .err_count   (err_count),
      .sum_abs_err (sum_abs_err),
      .max_abs_err (max_abs_err),
      .sum_err     (sum_err),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- multiplier under test ----------------
   // mode 0 exact, 1 lsb cleared, 2 always zero, 3 random per-pair error table
   function automatic logic [PW-1:0] amul(input int a, input int b);
      int p;
      p = a * b;
      case (mode)
         0:       return PW'(p);
         1:       return PW'(p & ~1);
         2:       return '0;
         default: return PW'(p) ^ err_tab[a * OPS + b];
      endcase
   endfunction

   always @(posedge clk) begin
      mpipe[0] <= amul(int'(mul_a), int'(mul_b));
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_c = mpipe[LAT-1];

   // ---------------- reference model ----------------
   // Statistics over the first npairs pairs in a-outer / b-inner order
   function automatic exp_t model(input int npairs);
      exp_t   e;
      int     a;
      int     b;
      longint d;
      longint ad;
      e.cnt = 0; e.sum_abs = 0; e.max_abs = 0; e.bias = 0; e.done_cyc = 0;
      for (int k = 0; k < npairs; k++) begin
         a = k / OPS;
         b = k % OPS;
         d = longint'(amul(a, b)) - longint'(a * b);
         e.bias += d;
         if (d != 0) begin
            ad = (d < 0) ? -d : d;
            e.cnt++;
            e.sum_abs += ad;
            if (ad > e.max_abs) e.max_abs = ad;
         end
      end
      return e;
   endfunction

   task automatic fill_tab();
      for (int i = 0; i < N; i++)
         err_tab[i] = ($urandom_range(0, 2) == 0) ? '0 : PW'($urandom_range(1, N - 1));
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input longint act, input longint exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic check_stats(input string tag, input exp_t e);
      check({tag, "_err_count"}, longint'(err_count), e.cnt);
      check({tag, "_sum_abs_err"}, longint'(sum_abs_err), e.sum_abs);
      check({tag, "_max_abs_err"}, longint'(max_abs_err), e.max_abs);
`ifdef APPROX_ERR_SWEEP_ERR_BIAS_EN
      check({tag, "_sum_err"}, longint'($signed(sum_err)), e.bias);
`else
      check({tag, "_sum_err"}, longint'(sum_err), 0);
`endif
   endtask

   task automatic check_zero(input string tag);
      exp_t z;
      z.cnt = 0; z.sum_abs = 0; z.max_abs = 0; z.bias = 0; z.done_cyc = 0;
      check({tag, "_busy"}, longint'(busy), 0);
      check({tag, "_done"}, longint'(done), 0);
      check({tag, "_mul_a"}, longint'(mul_a), 0);
      check({tag, "_mul_b"}, longint'(mul_b), 0);
      check({tag, "_state"}, longint'(dbg_state), longint'(ST_IDLE));
      check_stats(tag, z);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk) begin
      exp_t          e;
      logic [PW-1:0] p;
      #1;
      if (!rst) begin
         if (busy) begin
            if (pair_q.size() == 0) begin
               check("busy_without_sweep", longint'(busy), 0);
            end else begin
               p = pair_q.pop_front();
               check("operand_order", longint'({mul_a, mul_b}), longint'(p));
            end
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", longint'(done), 0);
            end else begin
               e = exp_q.pop_front();
               check("done_cycle", longint'(cyc), longint'(e.done_cyc));
               check("pairs_left_at_done", longint'(pair_q.size()), 0);
               check_stats("done", e);
            end
         end
      end
   end

   // ---------------- driver ----------------
   // One sweep in multiplier mode m. abort_k / rst_k interrupt at that RUN
   // cycle index; restart_k pulses start while busy. Negative means unused.
   task automatic run_sweep(input int m, input int abort_k, input int rst_k, input int restart_k);
      exp_t             e;
      logic [WIDTH-1:0] av;
      logic [WIDTH-1:0] bv;
      bit               full;
      mode = m;
      full = (abort_k < 0) && (rst_k < 0);
      @(negedge clk);
      e = model(N);
      e.done_cyc = cyc + 1 + N + LAT;
      if (full) exp_q.push_back(e);
      for (int a = 0; a < OPS; a++) begin
         for (int b = 0; b < OPS; b++) begin
            av = WIDTH'(a);
            bv = WIDTH'(b);
            pair_q.push_back({av, bv});
         end
      end
      for (int i = 0; i < LAT; i++) pair_q.push_back('1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int r = 0; r < N + LAT + 20; r++) begin
         if (full && exp_q.size() == 0) break;
         if (r == restart_k) start = 1'b1;
         if (r == abort_k) begin
            abort = 1'b1;
            pair_q.delete();
            @(negedge clk);
            abort = 1'b0;
            check("abort_busy", longint'(busy), 0);
            check("abort_state", longint'(dbg_state), longint'(ST_IDLE));
            repeat (LAT + 3) @(negedge clk);
            check_stats("abort_frozen", model(abort_k - LAT));
            return;
         end
         if (r == rst_k) begin
            #2;
            rst = 1'b1;
            pair_q.delete();
            exp_q.delete();
            #1;
            check_zero("rst_mid_run");
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         @(negedge clk);
         start = 1'b0;
      end
      if (exp_q.size() != 0) begin
         check("sweep_timeout", longint'(exp_q.size()), 0);
         exp_q.delete();
         pair_q.delete();
      end
      repeat (3) @(negedge clk);
      check_stats("held", e);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      exp_t hold;
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < N; i++) err_tab[i] = '0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      run_sweep(0, -1, -1, -1);      // exact multiplier: no errors
      run_sweep(1, -1, -1, 40);      // lsb cleared, start pulsed while busy
      run_sweep(2, -1, -1, -1);      // constant zero result
      fill_tab();
      run_sweep(3, 100, -1, -1);     // abort at RUN cycle 100
      run_sweep(3, -1, -1, -1);      // fresh start clears partial statistics

      // start and abort together in IDLE: nothing starts, statistics hold
      hold = model(N);
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", longint'(busy), 0);
      check("start_abort_state", longint'(dbg_state), longint'(ST_IDLE));
      repeat (3) @(negedge clk);
      check_stats("start_abort_hold", hold);

      fill_tab();
      run_sweep(3, -1, 120, -1);     // reset in the middle of RUN
      run_sweep(1, -1, -1, -1);      // full sweep after reset

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, got t=%0t", $time);
      $fatal(1);
   end

endmodule
